abcde_seq_ctrl: RTL and testbench



---
 rtl/abcde_seq_ctrl_if.sv | 32 +++
 rtl/abcde_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_abcde_seq_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/abcde_seq_ctrl_if.sv
// abcde_seq_ctrl_if
//   Bundles the sequencer/target handshake of abcde_seq_ctrl.
//   master : the controller (drives a,b,c,d and status; receives start, abort, e)
//   slave  : the sequencer/target side (drives start, abort, e; observes the rest)
//   Signals: start, abort, e, a, b, c, d, busy, done, err, e_lat[3:0],
//            pass_cnt[CNT_W-1:0]
interface abcde_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             e;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       e_lat;
    logic [CNT_W-1:0] pass_cnt;

    modport master (
        input  start, abort, e,
        output a, b, c, d, busy, done, err, e_lat, pass_cnt
    );

    modport slave (
        output start, abort, e,
        input  a, b, c, d, busy, done, err, e_lat, pass_cnt
    );
endinterface

// File: rtl/abcde_seq_ctrl.sv
// abcde_seq_ctrl
//   Drives the a -> b -> c(+d) handshake into the target, then waits for e
//   within 1..E_MAX_DLY cycles after d. A timeout re-runs the whole sequence
//   up to RETRIES times before flagging err. Reports the e latency of the last
//   successful attempt and a saturating count of passes.
//   Ports: clk, rst_n (async, active low), bus (abcde_seq_ctrl_if.master).
//
//   state  | meaning
//   IDLE   | waiting for start, all drives low
//   PH_A   | a high
//   PH_B   | b high
//   PH_C   | c and d high
//   WAIT_E | waiting for e, timer running (first cycle is w=1)
//   GAP    | one all-low cycle between a timeout and the retry
module abcde_seq_ctrl #(
    parameter int E_MAX_DLY = 4,
    parameter int RETRIES   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    abcde_seq_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE, PH_A, PH_B, PH_C, WAIT_E, GAP
    } state_t;

    // Down-counter: loaded at w=1, terminal count (0) marks w=E_MAX_DLY.
    localparam logic [3:0] TMR_INIT  = 4'(E_MAX_DLY - 1);
    localparam logic [3:0] DLY_MAX   = 4'(E_MAX_DLY);
    localparam logic [2:0] RETRY_MAX = 3'(RETRIES);

    state_t           state_q, state_d;
    logic [3:0]       tmr_q, tmr_d;
    logic [2:0]       retry_q, retry_d;
    logic             a_q, b_q, c_q, d_q, busy_q, done_q, err_q;
    logic             a_d, b_d, c_d, d_d, busy_d, done_d, err_d;
    logic [3:0]       e_lat_q, e_lat_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic             done_ev, err_ev;
    logic [3:0]       w_cur;

    assign w_cur = DLY_MAX - tmr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            retry_q <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            e_lat_q <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            e_lat_q <= e_lat_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        done_ev = 1'b0;
        err_ev  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = PH_A;
                    retry_d = '0;
                end
            end
            PH_A: state_d = PH_B;
            PH_B: state_d = PH_C;
            PH_C: begin
                state_d = WAIT_E;
                tmr_d   = TMR_INIT;
            end
            WAIT_E: begin
                if (bus.e) begin
                    done_ev = 1'b1;
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = GAP;
                    end else begin
                        err_ev  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            GAP:     state_d = PH_A;
            default: state_d = IDLE;
        endcase
        // abort wins over both completion and timeout
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            done_ev = 1'b0;
            err_ev  = 1'b0;
        end
    end

    // Outputs are derived from the next state so that they are registered
    // and line up with the state they describe.
    always_comb begin
        a_d     = (state_d == PH_A);
        b_d     = (state_d == PH_B);
        c_d     = (state_d == PH_C);
        d_d     = (state_d == PH_C);
        busy_d  = (state_d != IDLE);
        done_d  = done_ev;
        err_d   = err_ev;
        e_lat_d = done_ev ? w_cur : e_lat_q;
        pass_d  = pass_q;
        if (done_ev && pass_q != {CNT_W{1'b1}})
            pass_d = pass_q + 1'b1;
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.c        = c_q;
    assign bus.d        = d_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.e_lat    = e_lat_q;
    assign bus.pass_cnt = pass_q;

endmodule

// File: tb/tb_abcde_seq_ctrl.sv
module tb_abcde_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    abcde_seq_ctrl_if #(.CNT_W(16)) bus ();
    abcde_seq_ctrl_if #(.CNT_W(2))  bus2 ();

    // the saturating instance sees exactly the same stimulus
    assign bus2.start = bus.start;
    assign bus2.abort = bus.abort;
    assign bus2.e     = bus.e;

    abcde_seq_ctrl #(.E_MAX_DLY(4), .RETRIES(1), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    abcde_seq_ctrl #(.E_MAX_DLY(4), .RETRIES(1), .CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] drv();
        return {bus.a, bus.b, bus.c, bus.d};
    endfunction

    // Entered in the PH_A cycle; returns in the WAIT_E w=1 cycle.
    task automatic phases(input string tag);
        chk({tag, "_a"}, drv(), 4'b1000);
        chk({tag, "_busy"}, bus.busy, 1'b1);
        step();
        chk({tag, "_b"}, drv(), 4'b0100);
        step();
        chk({tag, "_cd"}, drv(), 4'b0011);
        step();
        chk({tag, "_w1"}, {drv(), bus.done, bus.err}, 6'b0);
    endtask

    // Full run with e arriving at w=k (k in 1..4).
    task automatic run_ok(input string tag, input int k, input int p16, input int p2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        phases(tag);
        for (int w = 1; w <= k; w++) begin
            bus.e = (w == k);
            step();
        end
        bus.e = 1'b0;
        chk({tag, "_done"}, {bus.done, bus.err, bus.busy}, 3'b100);
        chk({tag, "_lat"}, bus.e_lat, 32'(k));
        chk({tag, "_pcnt"}, bus.pass_cnt, 32'(p16));
        chk({tag, "_pcnt2"}, bus2.pass_cnt, 32'(p2));
        step();
        chk({tag, "_done_low"}, bus.done, 1'b0);
    endtask

    // Protocol monitor: one-hot drives, d follows c, a ##1 b ##1 c order,
    // done/err exclusive.
    logic pa = 1'b0, pb = 1'b0, pa2 = 1'b0, pb2 = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert ((32'(bus.a) + 32'(bus.b) + 32'(bus.c)) <= 1 && bus.d === bus.c
                    && !(bus.done && bus.err) && (!bus.b || pa) && (!bus.c || pb))
            else begin
                n_chk = n_chk + 1;
                $error("FAIL ap_abcde: observed abcd=%b%b%b%b done=%b err=%b", bus.a, bus.b,
                       bus.c, bus.d, bus.done, bus.err);
            end
            assert ((32'(bus2.a) + 32'(bus2.b) + 32'(bus2.c)) <= 1 && bus2.d === bus2.c
                    && !(bus2.done && bus2.err) && (!bus2.b || pa2) && (!bus2.c || pb2))
            else begin
                n_chk = n_chk + 1;
                $error("FAIL ap_abcde2: observed abcd=%b%b%b%b done=%b err=%b", bus2.a,
                       bus2.b, bus2.c, bus2.d, bus2.done, bus2.err);
            end
        end
        pa  = bus.a;
        pb  = bus.b;
        pa2 = bus2.a;
        pb2 = bus2.b;
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.e     = 1'b0;
        step();
        step();
        chk("rst_drv", {drv(), bus.busy, bus.done, bus.err}, 7'b0);
        chk("rst_lat", bus.e_lat, 4'd0);
        chk("rst_pcnt", bus.pass_cnt, 16'd0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", bus.busy, 1'b0);

        // T1: e at w=1
        run_ok("t1", 1, 1, 1);

        // T2a: e at w=4 (window edge)
        run_ok("t2a", 4, 2, 2);

        // T2b: e late -> timeout, GAP (e in GAP ignored), retry passes at w=1
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        phases("t2b");
        for (int w = 1; w <= 4; w++) step();
        chk("t2b_gap", {drv(), bus.busy, bus.done, bus.err}, 7'b0000100);
        bus.e = 1'b1;
        step();
        bus.e = 1'b0;
        chk("t2b_gap_e_ign", bus.done, 1'b0);
        phases("t2b_r");
        bus.e = 1'b1;
        step();
        bus.e = 1'b0;
        chk("t2b_done", {bus.done, bus.err, bus.busy}, 3'b100);
        chk("t2b_lat", bus.e_lat, 4'd1);
        chk("t2b_pcnt", bus.pass_cnt, 16'd3);
        chk("t2b_pcnt2", bus2.pass_cnt, 2'd3);
        step();

        // T3: e never -> GAP, retry, err after second timeout
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        phases("t3");
        for (int w = 1; w <= 4; w++) step();
        chk("t3_gap", {drv(), bus.busy, bus.err}, 6'b000010);
        step();
        phases("t3_r");
        for (int w = 1; w <= 3; w++) step();
        chk("t3_pre_err", {bus.err, bus.busy}, 2'b01);
        step();
        chk("t3_err", {bus.done, bus.err, bus.busy}, 3'b010);
        chk("t3_lat_kept", bus.e_lat, 4'd1);
        chk("t3_pcnt", bus.pass_cnt, 16'd3);
        step();
        chk("t3_err_low", bus.err, 1'b0);

        // T4: abort at w=2 together with e
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        phases("t4");
        step();
        bus.e     = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.e     = 1'b0;
        bus.abort = 1'b0;
        chk("t4_abort", {drv(), bus.busy, bus.done, bus.err}, 7'b0);
        chk("t4_pcnt", bus.pass_cnt, 16'd3);
        chk("t4_lat", bus.e_lat, 4'd1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("t4_start_abort", {bus.a, bus.busy}, 2'b00);

        // T5: reset during PH_B, then a normal run with e at w=2
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("t5_phb", drv(), 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_now", {drv(), bus.busy}, 5'b0);
        chk("t5_rst_pcnt", bus.pass_cnt, 16'd0);
        step();
        rst_n = 1'b1;
        step();
        run_ok("t5", 2, 1, 1);

        // T6: saturation on the 2-bit instance; e in PH_A / PH_C ignored
        for (int r = 0; r < 4; r++) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            bus.e = (r == 0);
            chk("t6_a", drv(), 4'b1000);
            step();
            bus.e = 1'b0;
            chk("t6_b", {drv(), bus.done}, 5'b01000);
            bus.e = (r == 1);
            step();
            chk("t6_cd", drv(), 4'b0011);
            step();
            chk("t6_w1", {bus.done, bus.busy}, 2'b01);
            for (int w = 1; w <= ((r == 1) ? 2 : 1); w++) begin
                bus.e = (w == ((r == 1) ? 2 : 1));
                step();
            end
            bus.e = 1'b0;
            chk("t6_done", bus.done, 1'b1);
            chk("t6_lat", bus.e_lat, (r == 1) ? 4'd2 : 4'd1);
            chk("t6_pcnt", bus.pass_cnt, 32'(r + 2));
            chk("t6_pcnt2", bus2.pass_cnt, (r == 0) ? 32'd2 : 32'd3);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
